async_fifo_rd_adapter: RTL and testbench

- Read-domain consumer placed directly downstream of the async FIFO. Runs entirely on the FIFO's read clock.
- Turns the FIFO's read interface (empty / r_en / r_valid / r_data) into a valid/ready stream for the pipeline.
- Prefetches words into a small local buffer and tracks reads still in flight, so the buffer never overflows and downstream stalls never lose data.
- Provides a flush that discards buffered and in-flight words.

---
 rtl/async_fifo_rd_adapter.sv | 113 +++++++++++
 tb/tb_async_fifo_rd_adapter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_adapter.sv
// Async-FIFO read-side adapter: fifo_r_en -> m_valid in 2 clk, credit-limited prefetch into BUF_DEPTH entries so m_ready stalls never lose data.
// Optional RD_ADAPTER_STALL_CNT_EN adds a saturating stall_cnt output.
`timescale 1ns/1ps
module async_fifo_rd_adapter #(
  parameter int DATA_SIZE = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        fifo_empty,
  output logic                        fifo_r_en,
  input  logic                        fifo_r_valid,
  input  logic [DATA_SIZE-1:0]        fifo_r_data,
  output logic                        m_valid,
  output logic [DATA_SIZE-1:0]        m_data,
  input  logic                        m_ready,
  input  logic                        flush,
  output logic [$clog2(BUF_DEPTH):0]  occupancy,
  output logic                        err
`ifdef RD_ADAPTER_STALL_CNT_EN
  ,
  output logic [15:0]                 stall_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = PW + 3;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  logic [DATA_SIZE-1:0] r_buf [BUF_DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_count;
  logic [CW-1:0]        r_inflight;
  logic [CW-1:0]        r_drop_pend;
  logic                 r_err;

  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;
  logic                 w_spur;
  logic                 w_issue;
  logic [XW-1:0]        w_used;
  logic [XW-1:0]        w_avail;
  logic [CW-1:0]        w_pend_sum;
  logic [CW-1:0]        w_pend_next;

  assign m_valid   = (r_count != '0);
  assign m_data    = r_buf[r_rd_ptr];
  assign occupancy = r_count;
  assign err       = r_err;

  // Credit compare kept unsigned: issue when DEPTH + pop exceeds everything already claimed.
  assign w_pop     = m_valid & m_ready;
  assign w_used    = XW'(r_count) + XW'(r_inflight) + XW'(r_drop_pend);
  assign w_avail   = XW'(BUF_DEPTH) + XW'(w_pop);
  assign w_issue   = resetn & ~fifo_empty & ~flush & (w_avail > w_used);
  assign fifo_r_en = w_issue;

  assign w_drop = fifo_r_valid & (r_drop_pend != '0);
  assign w_spur = fifo_r_valid & (r_drop_pend == '0) & (r_inflight == '0);
  assign w_push = fifo_r_valid & (r_drop_pend == '0) & (r_inflight != '0);

  assign w_pend_sum  = r_drop_pend + r_inflight;
  assign w_pend_next = (fifo_r_valid && (w_pend_sum != '0)) ? (w_pend_sum - CW'(1)) : w_pend_sum;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_inflight  <= '0;
      r_drop_pend <= '0;
    end else if (flush) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_inflight  <= '0;
      r_drop_pend <= w_pend_next;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
      if (w_drop) r_drop_pend <= r_drop_pend - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)     r_err <= 1'b0;
    else if (w_spur) r_err <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) r_buf[r_wr_ptr] <= fifo_r_data;
  end

`ifdef RD_ADAPTER_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                              r_stall_cnt <= '0;
    else if (flush)                                           r_stall_cnt <= '0;
    else if (m_valid && !m_ready && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign stall_cnt = r_stall_cnt;
`endif

  a_count_bound: assert property (@(posedge clk) disable iff (!resetn) r_count <= DEPTH_C);

endmodule

// File: tb/tb_async_fifo_rd_adapter.sv
// Bench for async_fifo_rd_adapter: behavioural FIFO with variable read latency plus a word-level scoreboard.
`timescale 1ns/1ps
module tb_async_fifo_rd_adapter;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic          fifo_r_valid;
  logic [DW-1:0] fifo_r_data;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          flush;
  logic [OW-1:0] occupancy;
  logic          err;
`ifdef RD_ADAPTER_STALL_CNT_EN
  logic [15:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  async_fifo_rd_adapter #(.DATA_SIZE(DW), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .fifo_empty(fifo_empty), .fifo_r_en(fifo_r_en),
    .fifo_r_valid(fifo_r_valid), .fifo_r_data(fifo_r_data), .m_valid(m_valid),
    .m_data(m_data), .m_ready(m_ready), .flush(flush), .occupancy(occupancy), .err(err)
`ifdef RD_ADAPTER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  typedef struct { logic [DW-1:0] data; int id; bit arrived; } ent_t;
  typedef struct { logic [DW-1:0] data; int id; int due; } ret_t;

  logic [DW-1:0] fifo_q[$];   // words still inside the async FIFO
  ret_t          ret_q[$];    // words read from the FIFO, on their way back
  ent_t          exp_q[$];    // words owed to the consumer, oldest first
  logic [DW-1:0] deliv_q[$];

  int  n_checks = 0, n_errors = 0;
  int  cyc = 0, next_id = 0, last_due = 0, cur_id = -1;
  int  lat_min = 1, lat_max = 1, exp_stall = 0;
  bit  force_empty = 0, inject_spur = 0, exp_err = 0;
  bit  s_ren, s_mv, s_acc;
  logic [DW-1:0] s_md;
  logic [OW-1:0] s_occ;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_arrived();
    int n = 0;
    foreach (exp_q[j]) if (exp_q[j].arrived) n++;
    return n;
  endfunction

  task automatic model_clear();
    exp_q.delete(); ret_q.delete();
    fifo_r_valid = 1'b0; cur_id = -1;
    exp_err = 0; exp_stall = 0; inject_spur = 0;
  endtask

  // One clock: check outputs against the model before the edge, then advance the model.
  task automatic cycle();
    bit fl, rv, rdy, mv, exp_ren, rv_real, ok;
    int arr, credit, id, lat, due;
    ent_t e;
    ret_t r;
    fifo_empty = (fifo_q.size() == 0) || force_empty;
    #1;
    arr = model_arrived();
    mv  = (arr > 0);
    check_eq("m_valid", m_valid, mv);
    check_eq("occupancy", occupancy, arr);
    if (mv) check_eq("m_data", m_data, exp_q[0].data);
    check_eq("err", err, exp_err);
`ifdef RD_ADAPTER_STALL_CNT_EN
    check_eq("stall_cnt", stall_cnt, exp_stall);
`endif
    rv_real = fifo_r_valid && (cur_id >= 0);
    credit  = DEPTH - arr - (ret_q.size() + int'(rv_real)) + int'(mv && m_ready);
    exp_ren = resetn && !fifo_empty && !flush && (credit > 0);
    check_eq("r_en", fifo_r_en, exp_ren);
    s_ren = fifo_r_en; s_mv = m_valid; s_md = m_data; s_occ = occupancy; s_acc = m_valid && m_ready;
    fl = flush; rv = fifo_r_valid; id = cur_id; rdy = m_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (!resetn) begin
      model_clear();
    end else begin
      if (fl) begin
        exp_q.delete();
        exp_stall = 0;
      end else begin
        if (mv && !rdy && exp_stall < 65535) exp_stall++;
        if (mv && rdy && exp_q.size() > 0) begin
          deliv_q.push_back(exp_q[0].data);
          void'(exp_q.pop_front());
        end
        if (rv) begin
          for (int j = 0; j < exp_q.size(); j++) begin
            if (!exp_q[j].arrived) begin
              if (exp_q[j].id == id) exp_q[j].arrived = 1;
              break;
            end
          end
        end
      end
      if (rv && id < 0) exp_err = 1;
      if (s_ren && fifo_q.size() > 0) begin
        e.data = fifo_q.pop_front(); e.id = next_id++; e.arrived = 0;
        exp_q.push_back(e);
        lat = $urandom_range(lat_max, lat_min);
        due = (cyc - 1 + lat > last_due) ? cyc - 1 + lat : last_due + 1;
        last_due = due;
        r.data = e.data; r.id = e.id; r.due = due;
        ret_q.push_back(r);
      end
    end
    if (inject_spur) begin
      fifo_r_valid = 1'b1; fifo_r_data = 32'hDEAD_BEEF; cur_id = -1; inject_spur = 0;
    end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      r = ret_q.pop_front();
      fifo_r_valid = 1'b1; fifo_r_data = r.data; cur_id = r.id;
    end else begin
      fifo_r_valid = 1'b0; cur_id = -1;
    end
    ok = (model_arrived() + ret_q.size() + ((fifo_r_valid && cur_id >= 0) ? 1 : 0)) <= DEPTH;
    check_eq("no_overflow", ok, 1);
  endtask

  task automatic drain(input int max_cyc);
    bit idle;
    m_ready = 1'b1; flush = 1'b0; force_empty = 0;
    for (int i = 0; i < max_cyc; i++) begin
      idle = (fifo_q.size() == 0) && (exp_q.size() == 0) && (ret_q.size() == 0) && !fifo_r_valid;
      if (idle) break;
      cycle();
    end
    idle = (fifo_q.size() == 0) && (exp_q.size() == 0) && (ret_q.size() == 0) && !fifo_r_valid;
    check_eq("drain_idle", idle, 1);
  endtask

  task automatic async_reset_pulse();
    #2;
    resetn = 1'b0;
    model_clear();
    #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_occupancy", occupancy, 0);
    check_eq("rst_r_en", fifo_r_en, 0);
    check_eq("rst_err", err, 0);
    resetn = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int first, last;
    resetn = 1'b0; fifo_empty = 1'b1; fifo_r_valid = 1'b0; fifo_r_data = '0;
    m_ready = 1'b0; flush = 1'b0;
    repeat (3) cycle();
    resetn = 1'b1;

    // single word: r_en at cycle 0, m_valid for exactly cycle 2
    fifo_q.push_back(32'hA5A5_0001);
    m_ready = 1'b1;
    cycle(); check_eq("single_ren_c0", s_ren, 1);
    cycle(); check_eq("single_mv_c1", s_mv, 0);
    cycle(); check_eq("single_mv_c2", s_mv, 1); check_eq("single_data", s_md, 32'hA5A5_0001);
    cycle(); check_eq("single_mv_c3", s_mv, 0); check_eq("single_occ", s_occ, 0);

    // streaming 16 words with no bubbles
    deliv_q.delete();
    for (int i = 0; i < 16; i++) fifo_q.push_back(i);
    first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      cycle();
      if (s_acc) begin
        if (first < 0) first = c;
        last = c;
      end
    end
    check_eq("stream_count", deliv_q.size(), 16);
    check_eq("stream_gapless", last - first, 15);
    for (int i = 0; i < deliv_q.size() && i < 16; i++) check_eq("stream_data", deliv_q[i], i);
    check_eq("stream_err", err, 0);

    // backpressure: buffer fills to DEPTH, reads stop, then drains in order
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fifo_q.push_back(32'h300 + i);
    repeat (6) cycle();
    check_eq("bp_occ", s_occ, 2);
    check_eq("bp_ren", s_ren, 0);
    check_eq("bp_fifo_left", fifo_q.size(), 6);
    deliv_q.delete();
    drain(40);
    check_eq("bp_count", deliv_q.size(), 8);
    for (int i = 0; i < deliv_q.size() && i < 8; i++) check_eq("bp_data", deliv_q[i], 32'h300 + i);

    // flush while a read is in flight
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'h400 + i);
    cycle();
    flush = 1'b1;
    cycle(); check_eq("flush_ren_forced", s_ren, 0);
    flush = 1'b0; m_ready = 1'b1;
    cycle(); check_eq("flush_occ", s_occ, 0); check_eq("flush_mv", s_mv, 0);
    deliv_q.delete();
    for (int i = 0; i < 10 && deliv_q.size() == 0; i++) cycle();
    check_eq("flush_next_word", deliv_q.size() > 0 ? deliv_q[0] : 32'h0, 32'h401);
    drain(30);

    // flush with two slow reads outstanding: both returns must be discarded
    lat_min = 3; lat_max = 3;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) fifo_q.push_back(32'h500 + i);
    repeat (2) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    deliv_q.delete();
    drain(40);
    check_eq("drop_next_word", deliv_q.size() > 0 ? deliv_q[0] : 32'h0, 32'h502);
    check_eq("drop_count", deliv_q.size(), 2);

    // randomized traffic, latency, backpressure and flushes
    lat_min = 1; lat_max = 3;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 1) == 0 && fifo_q.size() < 24) fifo_q.push_back($urandom);
      m_ready     = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 49) == 0);
      force_empty = ($urandom_range(0, 9) == 0);
      cycle();
    end
    drain(200);

    // asynchronous reset mid-stream, then resume
    lat_min = 1; lat_max = 1;
    m_ready = 1'b1;
    for (int i = 0; i < 10; i++) fifo_q.push_back(32'h600 + i);
    repeat (4) cycle();
    async_reset_pulse();
    deliv_q.delete();
    drain(60);
    check_eq("rst_resume_count", deliv_q.size(), 6);
    check_eq("rst_resume_first", deliv_q.size() > 0 ? deliv_q[0] : 32'h0, 32'h604);

`ifdef RD_ADAPTER_STALL_CNT_EN
    flush = 1'b1; cycle(); flush = 1'b0;
    m_ready = 1'b0;
    fifo_q.push_back(32'h800);
    for (int i = 0; i < 10 && !s_mv; i++) cycle();
    repeat (4) cycle();
    check_eq("stall5", stall_cnt, 5);
    drain(20);
`endif

    // spurious return while the buffer holds data
    m_ready = 1'b0;
    fifo_q.push_back(32'h700); fifo_q.push_back(32'h701);
    repeat (5) cycle();
    inject_spur = 1;
    cycle();
    cycle();
    check_eq("spur_err", err, 1);
    check_eq("spur_m_valid", m_valid, 1);
    check_eq("spur_occ", occupancy, 2);
    repeat (3) cycle();
    check_eq("spur_err_sticky", err, 1);
    deliv_q.delete();
    drain(20);
    check_eq("spur_count", deliv_q.size(), 2);
    check_eq("spur_first", deliv_q.size() > 0 ? deliv_q[0] : 32'h0, 32'h700);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
